// File: rtl/sram_pixel_writer.sv
// Pixel-word FIFO feeding an SRAM controller one write at a time, with frame address wrap.
// Define SRAM_WRITER_TIMEOUT_EN to add the write watchdog and the timeout_err output.
module sram_pixel_writer #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          FRAME_WORDS    = 76800,
    parameter logic [17:0] BASE_ADDR      = 18'h00000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    input  logic        frame_start,
    output logic        wr_en,
    output logic [17:0] address_inputs,
    output logic [15:0] wr_data,
    input  logic        wr_valid,
    input  logic        wr_busy,
    output logic        frame_done,
`ifdef SRAM_WRITER_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [17:0]   LAST_ADDR  = BASE_ADDR + 18'(FRAME_WORDS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (FRAME_WORDS < 1) begin : g_bad_frame
        $error("FRAME_WORDS must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    logic [1:0]    state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [17:0]   addr_q, addr_d;
    logic          fs_pend_q, fs_pend_d;
    logic          frame_done_q, frame_done_d;

`ifdef SRAM_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // Ready depends only on the registered count, never on pix_valid.
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign pix_ready  = !fifo_full;
    assign push       = pix_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !wr_busy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        wr_data_d    = wr_data_q;
        addr_d       = addr_q;
        fs_pend_d    = fs_pend_q;
        frame_done_d = 1'b0;
`ifdef SRAM_WRITER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    addr_d = BASE_ADDR;
                end
                if (pop) begin
                    state_d   = S_REQ;
                    wr_en_d   = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
`ifdef SRAM_WRITER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_REQ: begin
                if (frame_start) begin
                    fs_pend_d = 1'b1;
                end
                if (wr_valid) begin
                    state_d = S_RELEASE;
                    wr_en_d = 1'b0;
                end
`ifdef SRAM_WRITER_TIMEOUT_EN
                // Abandon the word but keep the address sequence intact.
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = S_RELEASE;
                    wr_en_d       = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (frame_start) begin
                    fs_pend_d = 1'b1;
                end
                if (!wr_busy) begin
                    state_d = S_IDLE;
                    // A latched frame_start replaces the increment and suppresses frame_done.
                    if (fs_pend_q || frame_start) begin
                        addr_d    = BASE_ADDR;
                        fs_pend_d = 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
                        addr_d       = BASE_ADDR;
                        frame_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 18'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            addr_q        <= BASE_ADDR;
            fs_pend_q     <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SRAM_WRITER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            addr_q        <= addr_d;
            fs_pend_q     <= fs_pend_d;
            frame_done_q  <= frame_done_d;
`ifdef SRAM_WRITER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_data        = wr_data_q;
    assign address_inputs = addr_q;
    assign frame_done     = frame_done_q;
    assign busy           = (state_q != S_IDLE) || !fifo_empty;
`ifdef SRAM_WRITER_TIMEOUT_EN
    assign timeout_err    = timeout_err_q;
`endif

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Scoreboard bench for sram_pixel_writer: two instances (4-word and 16-word frames) share stimulus.
`timescale 1ns/1ps
module tb_sram_pixel_writer;

    localparam int FRAME_A = 4;
    localparam int FRAME_B = 16;
    localparam int TMO     = 8;

    logic        clk = 1'b0;
    logic        rst_n, pix_valid, frame_start, wr_valid, wr_busy;
    logic [15:0] pix_data;
    logic        pix_ready_a, wr_en_a, frame_done_a, busy_a;
    logic [17:0] addr_a;
    logic [15:0] wr_data_a;
    logic        pix_ready_b, wr_en_b, frame_done_b, busy_b;
    logic [17:0] addr_b;
    logic [15:0] wr_data_b;
`ifdef SRAM_WRITER_TIMEOUT_EN
    logic        timeout_err_a, timeout_err_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    int  model_addr_a = 0, model_addr_b = 0;
    bit  fs_pend = 0;
    int  done_cnt = 0, fd_a_cnt = 0, fd_b_cnt = 0, wr_en_cycles = 0;
    bit  ctl_en = 1, busy_force = 0;
    int  vld_delay = 7;
    int  ctl_cnt = 0, ctl_busy_cnt = 0;

    always #5 clk = ~clk;

    sram_pixel_writer #(.FIFO_DEPTH(4), .FRAME_WORDS(FRAME_A), .BASE_ADDR(18'h00000),
                        .TIMEOUT_CYCLES(TMO)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_a),
        .pix_data(pix_data), .frame_start(frame_start), .wr_en(wr_en_a),
        .address_inputs(addr_a), .wr_data(wr_data_a), .wr_valid(wr_valid),
        .wr_busy(wr_busy), .frame_done(frame_done_a),
`ifdef SRAM_WRITER_TIMEOUT_EN
        .timeout_err(timeout_err_a),
`endif
        .busy(busy_a));

    sram_pixel_writer #(.FIFO_DEPTH(4), .FRAME_WORDS(FRAME_B), .BASE_ADDR(18'h00000),
                        .TIMEOUT_CYCLES(TMO)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_b),
        .pix_data(pix_data), .frame_start(frame_start), .wr_en(wr_en_b),
        .address_inputs(addr_b), .wr_data(wr_data_b), .wr_valid(wr_valid),
        .wr_busy(wr_busy), .frame_done(frame_done_b),
`ifdef SRAM_WRITER_TIMEOUT_EN
        .timeout_err(timeout_err_b),
`endif
        .busy(busy_b));

    // Controller model: wr_valid vld_delay cycles after wr_en rises, then busy for 2 cycles.
    initial begin : controller
        wr_valid = 1'b0;
        wr_busy  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wr_valid = 1'b0;
                ctl_cnt = 0;
                ctl_busy_cnt = 0;
            end else begin
                wr_valid = 1'b0;
                if (ctl_busy_cnt > 0) ctl_busy_cnt--;
                if (wr_en_a && ctl_en) begin
                    ctl_cnt++;
                    if (ctl_cnt >= vld_delay) begin
                        wr_valid = 1'b1;
                        ctl_cnt = 0;
                        ctl_busy_cnt = 2;
                    end
                end else begin
                    ctl_cnt = 0;
                end
            end
            wr_busy = busy_force || (ctl_busy_cnt > 0);
        end
    end

    task automatic advance_model();
        if (fs_pend) begin
            model_addr_a = 0;
            model_addr_b = 0;
            fs_pend = 0;
        end else begin
            model_addr_a = (model_addr_a == FRAME_A - 1) ? 0 : model_addr_a + 1;
            model_addr_b = (model_addr_b == FRAME_B - 1) ? 0 : model_addr_b + 1;
        end
    endtask

    // Monitor: a write completes on a cycle with wr_en && wr_valid.
    initial begin : monitor
        int run_len;
        logic [15:0] exp_d;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_addr_a = 0;
                model_addr_b = 0;
                fs_pend = 0;
                run_len = 0;
            end else begin
                if (frame_done_a) fd_a_cnt++;
                if (frame_done_b) fd_b_cnt++;
                if (wr_en_a) begin
                    wr_en_cycles++;
                    run_len++;
                end else begin
                    run_len = 0;
                end
                if (wr_en_a && wr_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_write data %h addr %h", wr_data_a, addr_a);
                    end else begin
                        exp_d = exp_q.pop_front();
                        if (wr_data_a !== exp_d) begin
                            errors++;
                            $display("FAIL sb_data got %h exp %h", wr_data_a, exp_d);
                        end
                    end
                    checks++;
                    if (addr_a !== 18'(model_addr_a)) begin
                        errors++;
                        $display("FAIL sb_addr_a got %h exp %h", addr_a, 18'(model_addr_a));
                    end
                    checks++;
                    if (addr_b !== 18'(model_addr_b)) begin
                        errors++;
                        $display("FAIL sb_addr_b got %h exp %h", addr_b, 18'(model_addr_b));
                    end
                    checks++;
                    if ({wr_en_b, wr_data_b, pix_ready_b, busy_b} !== {wr_en_a, wr_data_a, pix_ready_a, busy_a}) begin
                        errors++;
                        $display("FAIL sb_twin got %h exp %h", {wr_en_b, wr_data_b, pix_ready_b, busy_b},
                                 {wr_en_a, wr_data_a, pix_ready_a, busy_a});
                    end
                    done_cnt++;
                    advance_model();
                    run_len = 0;
                end
`ifdef SRAM_WRITER_TIMEOUT_EN
                else if (run_len == TMO) begin
                    if (exp_q.size() > 0) exp_d = exp_q.pop_front();
                    advance_model();
                    run_len = 0;
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        busy_force = 1'b0;
        ctl_en = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        done_cnt = 0;
        fd_a_cnt = 0;
        fd_b_cnt = 0;
        wr_en_cycles = 0;
    endtask

    task automatic push_word(input logic [15:0] d);
        int t;
        t = 0;
        pix_valid = 1'b1;
        pix_data = d;
        while (!pix_ready_a && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready_a) begin
            checks++;
            errors++;
            $display("FAIL push_ready got 0 exp 1 data %h", d);
            pix_valid = 1'b0;
        end else begin
            exp_q.push_back(d);
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt < n) begin
            errors++;
            $display("FAIL wait_writes got %0d exp %0d", done_cnt, n);
        end
    endtask

    task automatic wait_wr_en(input logic lvl);
        int t;
        t = 0;
        while (wr_en_a !== lvl && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (wr_en_a !== lvl) begin
            errors++;
            $display("FAIL wait_wr_en got %b exp %b", wr_en_a, lvl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks += 6;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", wr_en_a); end
        if (wr_data_a !== 16'h0) begin errors++; $display("FAIL rst_wr_data got %h exp 0000", wr_data_a); end
        if (addr_a !== 18'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000", addr_a); end
        if (frame_done_a !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_a); end
        if (pix_ready_a !== 1'b1) begin errors++; $display("FAIL rst_pix_ready got %b exp 1", pix_ready_a); end
`ifdef SRAM_WRITER_TIMEOUT_EN
        checks++;
        if (timeout_err_a !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b exp 0", timeout_err_a); end
`endif
        do_reset();
        checks++;
        if (pix_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got %b%b exp 10", pix_ready_a, busy_a);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        vld_delay = 7;
        push_word(16'hABCD);
        checks++;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", wr_en_a); end
        wait_writes(1);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_en_cycles != 7) begin errors++; $display("FAIL wr_en_width got %0d exp 7", wr_en_cycles); end
        checks++;
        if (busy_a !== 1'b0 || wr_en_a !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got %b%b exp 00", busy_a, wr_en_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vld_delay = 2;
        busy_force = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(16'(16'hB000 + i));
        repeat (2) @(negedge clk);
        checks++;
        if (pix_ready_a !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", pix_ready_a); end
        busy_force = 1'b0;
        for (int i = 4; i < 9; i++) push_word(16'(16'hB000 + i));
        wait_writes(9);
        repeat (6) @(negedge clk);
        checks++;
        if (fd_a_cnt != 2) begin errors++; $display("FAIL frame_done_a got %0d exp 2", fd_a_cnt); end
        checks++;
        if (fd_b_cnt != 0) begin errors++; $display("FAIL frame_done_b got %0d exp 0", fd_b_cnt); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_busy_hold();
        int hi;
        do_reset();
        vld_delay = 3;
        busy_force = 1'b1;
        @(negedge clk);
        push_word(16'hC001);
        push_word(16'hC002);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en_a) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL busy_hold_wr_en got %0d exp 0", hi); end
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_hold_busy got %b exp 1", busy_a); end
        busy_force = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL busy_fall_same got %b exp 0", wr_en_a); end
        @(negedge clk);
        checks++;
        if (wr_en_a !== 1'b1) begin errors++; $display("FAIL busy_fall_next got %b exp 1", wr_en_a); end
        wait_writes(2);
    endtask

    task automatic test_frame_start();
        do_reset();
        vld_delay = 3;
        for (int i = 0; i < 6; i++) push_word(16'(16'h5000 + i));
        wait_writes(5);
        wait_wr_en(1'b0);
        wait_wr_en(1'b1);
        frame_start = 1'b1;
        fs_pend = 1;
        @(negedge clk);
        frame_start = 1'b0;
        push_word(16'h5006);
        wait_writes(7);
        repeat (6) @(negedge clk);
        checks++;
        if (fd_b_cnt != 0) begin errors++; $display("FAIL fs_frame_done_b got %0d exp 0", fd_b_cnt); end
        checks++;
        if (fd_a_cnt != 1) begin errors++; $display("FAIL fs_frame_done_a got %0d exp 1", fd_a_cnt); end
        frame_start = 1'b1;
        model_addr_a = 0;
        model_addr_b = 0;
        @(negedge clk);
        frame_start = 1'b0;
        push_word(16'h5007);
        wait_writes(8);
    endtask

    task automatic test_reset_mid();
        do_reset();
        vld_delay = 5;
        push_word(16'hD000);
        push_word(16'hD001);
        wait_writes(2);
        repeat (5) @(negedge clk);
        busy_force = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(16'(16'hD010 + i));
        busy_force = 1'b0;
        wait_wr_en(1'b1);
        checks++;
        if (addr_a !== 18'h2) begin errors++; $display("FAIL mid_addr got %h exp 00002", addr_a); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en_a !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got %b exp 0", wr_en_a); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy_a); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready_a !== 1'b1 || busy_a !== 1'b0 || wr_en_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_release got %b%b%b exp 100", pix_ready_a, busy_a, wr_en_a);
        end
        done_cnt = 0;
        push_word(16'hD0FF);
        wait_writes(1);
    endtask

`ifdef SRAM_WRITER_TIMEOUT_EN
    task automatic test_timeout();
        int run;
        do_reset();
        ctl_en = 1'b0;
        push_word(16'h7777);
        wait_wr_en(1'b1);
        run = 0;
        while (wr_en_a && run < 50) begin
            run++;
            @(negedge clk);
        end
        checks++;
        if (run != TMO) begin errors++; $display("FAIL tmo_wr_en_cycles got %0d exp %0d", run, TMO); end
        checks++;
        if (timeout_err_a !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", timeout_err_a); end
        ctl_en = 1'b1;
        vld_delay = 2;
        push_word(16'h8888);
        wait_writes(1);
        repeat (4) @(negedge clk);
        checks++;
        if (timeout_err_a !== 1'b1 || timeout_err_b !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky got %b%b exp 11", timeout_err_a, timeout_err_b);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'h0;
        frame_start = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_busy_hold();
        test_frame_start();
        test_reset_mid();
`ifdef SRAM_WRITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_pixel_writer.md
SRAM_PIXEL_WRITER -- requirements
Module: sram_pixel_writer

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, pixel buffer depth in words (power of two, >=2).
REQ-002: Parameter FRAME_WORDS, default 76800, SRAM words per frame (320x240 RGB565).
REQ-003: Parameter BASE_ADDR, default 18'h00000, SRAM address of frame word 0.
REQ-004: Parameter TIMEOUT_CYCLES, default 64, maximum wait for wr_valid (used only with the Configuration macro).
REQ-005: clk  in  1  single clock; all logic on posedge.
REQ-006: rst_n  in  1  asynchronous reset, active low.
REQ-007: pix_valid  in  1  upstream pixel word valid.
REQ-008: pix_ready  out  1  buffer can accept a word.
REQ-009: pix_data  in  16  pixel word.
REQ-010: frame_start  in  1  one-cycle pulse; the next write goes to BASE_ADDR.
REQ-011: wr_en  out  1  write request to the SRAM controller.
REQ-012: address_inputs  out  18  SRAM word address to the controller.
REQ-013: wr_data  out  16  data word presented to the controller's dq path.
REQ-014: wr_valid  in  1  controller write-valid indication.
REQ-015: wr_busy  in  1  controller write-busy indication.
REQ-016: frame_done  out  1  one-cycle pulse after the last word of a frame completes.
REQ-017: busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018: Words SHALL be pushed into the FIFO on any cycle where pix_valid && pix_ready; pix_ready = !full, registered-count based, with no combinational path from pix_valid.
REQ-019: The FSM SHALL have states IDLE, REQ and RELEASE.
REQ-020: IDLE -> REQ SHALL occur when the FIFO is non-empty and wr_busy==0; the FIFO head is popped into wr_data in the same cycle.
REQ-021: In REQ, wr_en SHALL be 1 (registered output); wr_data and address_inputs SHALL be held stable.
REQ-022: REQ -> RELEASE SHALL occur on the first cycle where wr_valid==1; wr_en is 0 from the following cycle.
REQ-023: RELEASE -> IDLE SHALL occur when wr_busy==0; the address advances on this transition.
REQ-024: Address advance SHALL be +1; if address==BASE_ADDR+FRAME_WORDS-1, it wraps to BASE_ADDR and frame_done pulses for exactly 1 cycle.
REQ-025: A frame_start received in IDLE SHALL set the address to BASE_ADDR on the next cycle; a frame_start received in REQ or RELEASE SHALL be latched and applied at RELEASE -> IDLE instead of the increment, with no frame_done.
REQ-026: Latency: a word accepted at cycle N SHALL raise wr_en no earlier than N+2 (empty FIFO, IDLE, wr_busy==0).
REQ-027: A simultaneous push and pop SHALL leave the count unchanged; a push is never accepted while full; a pop never occurs while empty.
REQ-028: Ordering SHALL be strict FIFO; no word is dropped except as stated in REQ-033.

Reset
REQ-029: On rst_n==0, asynchronously: FSM=IDLE, FIFO empty, address=BASE_ADDR, wr_en=0, wr_data=0, frame_done=0, pending frame_start cleared, pix_ready=1 (after release), busy=0.
REQ-030: Reset mid-write SHALL abandon the in-flight word and all buffered words; wr_en falls immediately.

Configuration
REQ-031: Macro SRAM_WRITER_TIMEOUT_EN SHALL enable the write watchdog and output port timeout_err (out, 1).
REQ-032: With the macro defined, a counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-033: With the macro defined, if the counter reaches TIMEOUT_CYCLES without wr_valid: wr_en -> 0, go to RELEASE, drop the word, still advance the address, and set timeout_err sticky until reset.
REQ-034: Without the macro, REQ SHALL wait indefinitely, and there is no timeout_err port or counter logic.

Verification
REQ-035: Reset, then push 0xABCD with the controller model returning wr_valid 7 cycles after wr_en -> one write to addr 0x00000, data 0xABCD; wr_en high exactly until the cycle after wr_valid.
REQ-036: FRAME_WORDS=4, stream 9 words back-to-back -> addresses 0,1,2,3,0,1,2,3,0; frame_done pulses twice; pix_ready low while 4 words are buffered.
REQ-037: Hold wr_busy=1 for 20 cycles with the FIFO non-empty -> wr_en stays 0; the first write starts the cycle after wr_busy falls.
REQ-038: frame_start pulsed during REQ at addr 0x00005 -> that word is written to 0x00005, the next to BASE_ADDR, and no frame_done occurs.
REQ-039: rst_n low while in REQ with 3 words buffered -> wr_en=0 immediately, busy=0, pix_ready=1 after release, next write to BASE_ADDR.
REQ-040: SRAM_WRITER_TIMEOUT_EN with TIMEOUT_CYCLES=8 and wr_valid never asserted -> wr_en drops after 8 REQ cycles, timeout_err=1 sticky, next word goes to address+1.
